// File: rtl/alu_sequencer_pkg.sv
// Shared widths, instruction field positions and opcode/funct/ALU encodings
// for the ALU issue/writeback sequencer.
`ifndef ALU_SEQ_PRJ_DEFINITION
`define ALU_SEQ_PRJ_DEFINITION
`define DATA_WIDTH 32
`define ALU_OPRN_WIDTH 6
`define REG_ADDR_WIDTH 5
`endif

package alu_sequencer_pkg;

  localparam int DATA_W  = `DATA_WIDTH;
  localparam int OPRN_W  = `ALU_OPRN_WIDTH;
  localparam int ADDR_W  = `REG_ADDR_WIDTH;
  localparam int INSTR_W = 32;
  localparam int FIELD_W = 6;
  localparam int IMM_W   = 16;
  localparam int SHAMT_W = 5;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  // shamt position relative to the 16-bit immediate field
  localparam int SHAMT_LSB = 6;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [FIELD_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [FIELD_W-1:0] OP_MULI  = 6'h1d;
  localparam logic [FIELD_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [FIELD_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [FIELD_W-1:0] OP_SLTI  = 6'h0a;

  localparam logic [FIELD_W-1:0] FN_ADD = 6'h20;
  localparam logic [FIELD_W-1:0] FN_SUB = 6'h22;
  localparam logic [FIELD_W-1:0] FN_MUL = 6'h2c;
  localparam logic [FIELD_W-1:0] FN_AND = 6'h24;
  localparam logic [FIELD_W-1:0] FN_OR  = 6'h25;
  localparam logic [FIELD_W-1:0] FN_NOR = 6'h27;
  localparam logic [FIELD_W-1:0] FN_SLT = 6'h2a;
  localparam logic [FIELD_W-1:0] FN_SLL = 6'h01;
  localparam logic [FIELD_W-1:0] FN_SRL = 6'h02;

  localparam logic [OPRN_W-1:0] ALU_NOP = 6'h00;
  localparam logic [OPRN_W-1:0] ALU_ADD = 6'h01;
  localparam logic [OPRN_W-1:0] ALU_SUB = 6'h02;
  localparam logic [OPRN_W-1:0] ALU_MUL = 6'h03;
  localparam logic [OPRN_W-1:0] ALU_AND = 6'h04;
  localparam logic [OPRN_W-1:0] ALU_OR  = 6'h05;
  localparam logic [OPRN_W-1:0] ALU_NOR = 6'h06;
  localparam logic [OPRN_W-1:0] ALU_SLT = 6'h07;
  localparam logic [OPRN_W-1:0] ALU_SLL = 6'h08;
  localparam logic [OPRN_W-1:0] ALU_SRL = 6'h09;

  typedef enum logic [1:0] {OP2_RT, OP2_SHAMT, OP2_SEXT, OP2_ZEXT} op2_sel_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  typedef struct packed {
    logic [OPRN_W-1:0] oprn;
    op2_sel_e          op2_sel;
    logic              shift;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [IMM_W-1:0]  imm;
  } decode_t;

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational instruction decoder: validity, ALU operation, operand-2
// source, shift flag, destination and the raw register/immediate fields.
module alu_instr_decode
  import alu_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               valid,
  output decode_t            dec
);

  logic [FIELD_W-1:0] op;
  logic [FIELD_W-1:0] funct;

  assign op    = instr[OP_LSB +: FIELD_W];
  assign funct = instr[FUNCT_LSB +: FIELD_W];

  always_comb begin
    valid       = 1'b1;
    dec         = '0;
    dec.op2_sel = OP2_RT;
    dec.rs      = instr[RS_LSB +: ADDR_W];
    dec.rt      = instr[RT_LSB +: ADDR_W];
    dec.imm     = instr[IMM_W-1:0];
    dec.dest    = instr[RD_LSB +: ADDR_W];
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: dec.oprn = ALU_ADD;
          FN_SUB: dec.oprn = ALU_SUB;
          FN_MUL: dec.oprn = ALU_MUL;
          FN_AND: dec.oprn = ALU_AND;
          FN_OR:  dec.oprn = ALU_OR;
          FN_NOR: dec.oprn = ALU_NOR;
          FN_SLT: dec.oprn = ALU_SLT;
          FN_SLL: begin
            dec.oprn    = ALU_SLL;
            dec.shift   = 1'b1;
            dec.op2_sel = OP2_SHAMT;
          end
          FN_SRL: begin
            dec.oprn    = ALU_SRL;
            dec.shift   = 1'b1;
            dec.op2_sel = OP2_SHAMT;
          end
          default: valid = 1'b0;
        endcase
      end
      OP_ADDI: begin dec.oprn = ALU_ADD; dec.op2_sel = OP2_SEXT; dec.dest = dec.rt; end
      OP_MULI: begin dec.oprn = ALU_MUL; dec.op2_sel = OP2_SEXT; dec.dest = dec.rt; end
      OP_ANDI: begin dec.oprn = ALU_AND; dec.op2_sel = OP2_ZEXT; dec.dest = dec.rt; end
      OP_ORI:  begin dec.oprn = ALU_OR;  dec.op2_sel = OP2_ZEXT; dec.dest = dec.rt; end
      OP_SLTI: begin dec.oprn = ALU_SLT; dec.op2_sel = OP2_SEXT; dec.dest = dec.rt; end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer in front of the combinational ALU.
// state  | meaning
// IDLE   | waiting for START; rejects unsupported instructions with ERR
// READ   | register-file read of rs/rt
// EXEC   | registered operands and opcode presented to the ALU
// WB     | result written back (unless rd/rt is r0), DONE high
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [INSTR_W-1:0]    INSTR,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  ZERO_FLAG,
  output logic                  RF_READ,
  output logic [ADDR_W-1:0]     RF_ADDR_R1,
  output logic [ADDR_W-1:0]     RF_ADDR_R2,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
  output logic                  RF_WRITE,
  output logic [ADDR_W-1:0]     RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_W-1:0]     ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO
);

  state_e                state_q, state_d;
  decode_t               dec_in, dec_q, dec_d;
  logic                  dec_valid;
  logic                  accept;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, result_q, result_d;
  logic [DATA_WIDTH-1:0] op2_mux;
  logic                  zero_q, zero_d, err_q, err_d;

  alu_instr_decode u_decode (
    .instr (INSTR),
    .valid (dec_valid),
    .dec   (dec_in)
  );

  assign accept = (state_q == S_IDLE) && START && dec_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (dec_q.op2_sel)
      OP2_RT:    op2_mux = RF_DATA_R2;
      OP2_SHAMT: op2_mux = DATA_WIDTH'(dec_q.imm[SHAMT_LSB +: SHAMT_W]);
      OP2_SEXT:  op2_mux = $unsigned(DATA_WIDTH'($signed(dec_q.imm)));
      OP2_ZEXT:  op2_mux = DATA_WIDTH'(dec_q.imm);
      default:   op2_mux = RF_DATA_R2;
    endcase
  end

  always_comb begin
    dec_d    = dec_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = (state_q == S_IDLE) && START && !dec_valid;
    if (accept) dec_d = dec_in;
    // shifts operate on rt, so operand 1 comes from the second read port
    if (state_q == S_READ) begin
      op1_d = dec_q.shift ? RF_DATA_R2 : RF_DATA_R1;
      op2_d = op2_mux;
    end
    if (state_q == S_EXEC) begin
      result_d = ALU_OUT;
      zero_d   = ALU_ZERO;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dec_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      dec_q    <= dec_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    BUSY       = (state_q != S_IDLE);
    DONE       = (state_q == S_WB);
    ERR        = err_q;
    RF_READ    = (state_q == S_READ);
    RF_ADDR_R1 = dec_q.rs;
    RF_ADDR_R2 = dec_q.rt;
    RF_WRITE   = (state_q == S_WB) && (dec_q.dest != '0);
    RF_ADDR_W  = dec_q.dest;
    RF_DATA_W  = result_q;
    RESULT     = result_q;
    ZERO_FLAG  = zero_q;
    ALU_OP1    = op1_q;
    ALU_OP2    = op2_q;
    ALU_OPRN   = ((state_q == S_EXEC) || (state_q == S_WB)) ? dec_q.oprn : ALU_NOP;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: behavioural register file and ALU around the sequencer,
// directed cases followed by random instructions against an arithmetic model.
module tb_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [31:0] INSTR = '0;
  logic        BUSY, DONE, ERR, ZERO_FLAG, RF_READ, RF_WRITE, ALU_ZERO;
  logic [31:0] RESULT, RF_DATA_R1, RF_DATA_R2, RF_DATA_W, ALU_OP1, ALU_OP2, ALU_OUT;
  logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [5:0]  ALU_OPRN;

  logic [31:0] rf     [32];
  logic [31:0] mdl_rf [32];
  logic        ld_en = 1'b0;
  logic [4:0]  ld_a = '0;
  logic [31:0] ld_d = '0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_result = '0;
  logic        exp_zero = 1'b0;

  logic [5:0] rfn [9] = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02};
  logic [5:0] iop [5] = '{6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0a};

  always #5 CLK = ~CLK;

  alu_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .INSTR(INSTR),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RESULT(RESULT), .ZERO_FLAG(ZERO_FLAG),
    .RF_READ(RF_READ), .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
    .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
    .RF_WRITE(RF_WRITE), .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO)
  );

  assign RF_DATA_R1 = rf[RF_ADDR_R1];
  assign RF_DATA_R2 = rf[RF_ADDR_R2];

  always @(posedge CLK) begin
    if (ld_en)         rf[ld_a] <= ld_d;
    else if (RF_WRITE) rf[RF_ADDR_W] <= RF_DATA_W;
  end

  always_comb begin
    ALU_OUT = '0;
    case (ALU_OPRN)
      6'd1: ALU_OUT = ALU_OP1 + ALU_OP2;
      6'd2: ALU_OUT = ALU_OP1 - ALU_OP2;
      6'd3: ALU_OUT = ALU_OP1 * ALU_OP2;
      6'd4: ALU_OUT = ALU_OP1 & ALU_OP2;
      6'd5: ALU_OUT = ALU_OP1 | ALU_OP2;
      6'd6: ALU_OUT = ~(ALU_OP1 | ALU_OP2);
      6'd7: ALU_OUT = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
      6'd8: ALU_OUT = ALU_OP1 << ALU_OP2[4:0];
      6'd9: ALU_OUT = ALU_OP1 >> ALU_OP2[4:0];
      default: ALU_OUT = '0;
    endcase
  end
  assign ALU_ZERO = (ALU_OUT == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(BUSY), 0);
    chk({tag, "_done"},  32'(DONE), 0);
    chk({tag, "_err"},   32'(ERR), 0);
    chk({tag, "_res"},   RESULT, 0);
    chk({tag, "_zf"},    32'(ZERO_FLAG), 0);
    chk({tag, "_rd"},    32'(RF_READ), 0);
    chk({tag, "_wr"},    32'(RF_WRITE), 0);
    chk({tag, "_ar1"},   32'(RF_ADDR_R1), 0);
    chk({tag, "_ar2"},   32'(RF_ADDR_R2), 0);
    chk({tag, "_aw"},    32'(RF_ADDR_W), 0);
    chk({tag, "_dw"},    RF_DATA_W, 0);
    chk({tag, "_op1"},   ALU_OP1, 0);
    chk({tag, "_op2"},   ALU_OP2, 0);
    chk({tag, "_oprn"},  32'(ALU_OPRN), 0);
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Instruction semantics straight from the ISA table, on the model register file.
  function automatic void model(input logic [31:0] ins, output logic ok,
                                output logic [5:0] oprn, output logic [31:0] a,
                                output logic [31:0] b, output logic [31:0] res,
                                output logic [4:0] dst);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, sh;
    logic [15:0] imm;
    logic [31:0] sx, zx;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; sh = ins[10:6];
    fn = ins[5:0];   imm = ins[15:0];
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0000, imm};
    ok = 1'b1; oprn = '0; res = '0;
    a = mdl_rf[rs]; b = mdl_rf[rt]; dst = ins[15:11];
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin oprn = 6'd1; res = a + b; end
        6'h22: begin oprn = 6'd2; res = a - b; end
        6'h2c: begin oprn = 6'd3; res = a * b; end
        6'h24: begin oprn = 6'd4; res = a & b; end
        6'h25: begin oprn = 6'd5; res = a | b; end
        6'h27: begin oprn = 6'd6; res = ~(a | b); end
        6'h2a: begin oprn = 6'd7; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        6'h01: begin oprn = 6'd8; a = mdl_rf[rt]; b = {27'd0, sh}; res = a << sh; end
        6'h02: begin oprn = 6'd9; a = mdl_rf[rt]; b = {27'd0, sh}; res = a >> sh; end
        default: ok = 1'b0;
      endcase
    end else begin
      dst = rt;
      case (op)
        6'h08: begin oprn = 6'd1; b = sx; res = a + b; end
        6'h1d: begin oprn = 6'd3; b = sx; res = a * b; end
        6'h0c: begin oprn = 6'd4; b = zx; res = a & b; end
        6'h0d: begin oprn = 6'd5; b = zx; res = a | b; end
        6'h0a: begin oprn = 6'd7; b = sx; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        default: ok = 1'b0;
      endcase
    end
  endfunction

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge CLK);
    ld_en = 1'b0;
    mdl_rf[a] = d;
  endtask

  task automatic issue(input logic [31:0] ins, input bit hold, input bit abort);
    logic        ok;
    logic [5:0]  oprn;
    logic [31:0] a, b, res;
    logic [4:0]  dst;
    model(ins, ok, oprn, a, b, res, dst);
    @(negedge CLK);
    START = 1'b1; INSTR = ins;
    @(negedge CLK);
    if (!ok) begin
      chk("err_pulse",  32'(ERR), 1);
      chk("err_busy",   32'(BUSY), 0);
      chk("err_rfread", 32'(RF_READ), 0);
      chk("err_oprn",   32'(ALU_OPRN), 0);
      chk("err_result", RESULT, exp_result);
      START = 1'b0;
      @(negedge CLK);
      chk("err_clear",  32'(ERR), 0);
      chk("err_idle",   32'(BUSY), 0);
      chk("err_nowr",   32'(RF_WRITE), 0);
      return;
    end
    chk("rd_busy", 32'(BUSY), 1);
    chk("rd_strobe", 32'(RF_READ), 1);
    chk("rd_addr1", 32'(RF_ADDR_R1), 32'(ins[25:21]));
    chk("rd_addr2", 32'(RF_ADDR_R2), 32'(ins[20:16]));
    chk("rd_oprn", 32'(ALU_OPRN), 0);
    chk("rd_done", 32'(DONE), 0);
    chk("rd_err", 32'(ERR), 0);
    if (!hold) begin START = 1'b0; INSTR = $urandom; end
    @(negedge CLK);
    chk("ex_busy", 32'(BUSY), 1);
    chk("ex_rdoff", 32'(RF_READ), 0);
    chk("ex_oprn", 32'(ALU_OPRN), 32'(oprn));
    chk("ex_op1", ALU_OP1, a);
    chk("ex_op2", ALU_OP2, b);
    chk("ex_done", 32'(DONE), 0);
    if (abort) begin
      RST = 1'b1;
      #1;
      chk_all_zero("abort");
      @(negedge CLK);
      chk("abort_done", 32'(DONE), 0);
      chk("abort_wr", 32'(RF_WRITE), 0);
      RST = 1'b0;
      exp_result = '0; exp_zero = 1'b0;
      chk("abort_rf", rf[dst], mdl_rf[dst]);
      return;
    end
    @(negedge CLK);
    chk("wb_done", 32'(DONE), 1);
    chk("wb_busy", 32'(BUSY), 1);
    chk("wb_result", RESULT, res);
    chk("wb_zero", 32'(ZERO_FLAG), 32'(res == 0));
    chk("wb_write", 32'(RF_WRITE), 32'(dst != 0));
    if (dst != 0) chk("wb_waddr", 32'(RF_ADDR_W), 32'(dst));
    chk("wb_wdata", RF_DATA_W, res);
    @(negedge CLK);
    if (dst != 0) mdl_rf[dst] = res;
    exp_result = res; exp_zero = (res == 0);
    chk("id_busy", 32'(BUSY), 0);
    chk("id_done", 32'(DONE), 0);
    chk("id_wr", 32'(RF_WRITE), 0);
    chk("id_oprn", 32'(ALU_OPRN), 0);
    chk("id_result", RESULT, exp_result);
    chk("id_zero", 32'(ZERO_FLAG), 32'(exp_zero));
    chk("rf_content", rf[dst], mdl_rf[dst]);
    if (hold) begin
      START = 1'b0;
      @(negedge CLK);
      chk("hold_single", 32'(BUSY), 0);
      chk("hold_noerr", 32'(ERR), 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;
    for (int i = 0; i < 32; i++) set_reg(5'(i), 32'd0);

    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd7);
    issue(enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 1'b0, 1'b1);
    issue(enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 1'b0, 1'b0);
    chk("add_result", RESULT, 32'd12);
    chk("add_zero", 32'(ZERO_FLAG), 0);
    chk("add_r3", rf[3], 32'd12);

    set_reg(5'd1, 32'd9);
    issue(enc_r(6'h22, 5'd1, 5'd1, 5'd4, 5'd0), 1'b0, 1'b0);
    chk("sub_result", RESULT, 32'd0);
    chk("sub_zero", 32'(ZERO_FLAG), 1);

    set_reg(5'd1, 32'd1);
    issue(enc_i(6'h08, 5'd1, 5'd5, 16'hFFFF), 1'b0, 1'b0);
    chk("addi_result", RESULT, 32'd0);

    set_reg(5'd1, 32'd0);
    issue(enc_i(6'h0d, 5'd1, 5'd5, 16'hFFFF), 1'b0, 1'b0);
    chk("ori_result", RESULT, 32'h0000FFFF);

    set_reg(5'd2, 32'd3);
    issue(enc_r(6'h01, 5'd0, 5'd2, 5'd6, 5'd4), 1'b0, 1'b0);
    chk("sll_result", RESULT, 32'd48);
    set_reg(5'd0, 32'hA5A5_0000);
    issue(enc_r(6'h01, 5'd0, 5'd2, 5'd0, 5'd4), 1'b0, 1'b0);
    chk("sll_r0_result", RESULT, 32'd48);
    chk("sll_r0_kept", rf[0], 32'hA5A5_0000);

    issue(32'hFC00_0000, 1'b0, 1'b0);
    chk("bad_result_held", RESULT, 32'd48);

    set_reg(5'd1, 32'd20);
    set_reg(5'd2, 32'd22);
    issue(enc_r(6'h20, 5'd1, 5'd2, 5'd7, 5'd0), 1'b1, 1'b0);
    chk("hold_r7", rf[7], 32'd42);

    for (int i = 0; i < 32; i++) set_reg(5'(i), $urandom);
    for (int n = 0; n < 60; n++) begin
      int          r;
      logic [31:0] ins;
      r = int'($urandom_range(0, 15));
      if (r < 9)       ins = enc_r(rfn[r], 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      else if (r < 14) ins = enc_i(iop[r-9], 5'($urandom), 5'($urandom), 16'($urandom));
      else             ins = $urandom;
      issue(ins, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue/writeback sequencer that sits directly upstream of the combinational ALU. It accepts one 32-bit R-type or I-type arithmetic/logic instruction on a START handshake and reads its operands from the external register file. It then drives ALU operands and opcode, captures the ALU result and zero flag, and writes the result back to the register file.

## Interface
- DATA_WIDTH, default 32: operand/result width. It must equal `DATA_WIDTH.
- CLK, in, 1: single clock; all state updates on the rising edge.
- RST, in, 1: asynchronous, active-high reset.
- START, in, 1: request; sampled only in IDLE.
- INSTR, in, 32: instruction; latched on an accepted START.
- BUSY, out, 1: high in every state except IDLE.
- DONE, out, 1: one-cycle pulse when writeback completes.
- ERR, out, 1: one-cycle pulse on an unsupported opcode/funct.
- RESULT, out, 32: last captured ALU result; held until the next capture.
- ZERO_FLAG, out, 1: last captured ALU ZERO; held.
- RF_READ, out, 1: register-file read strobe.
- RF_ADDR_R1, out, 5: rs address.
- RF_ADDR_R2, out, 5: rt address.
- RF_DATA_R1, in, 32: rs read data.
- RF_DATA_R2, in, 32: rt read data.
- RF_WRITE, out, 1: register-file write strobe.
- RF_ADDR_W, out, 5: destination address.
- RF_DATA_W, out, 32: write data.
- ALU_OP1, out, 32: ALU operand 1.
- ALU_OP2, out, 32: ALU operand 2.
- ALU_OPRN, out, 6: ALU operation code.
- ALU_OUT, in, 32: ALU result.
- ALU_ZERO, in, 1: ALU zero status.

## Operation
- States: IDLE, READ, EXEC, WB. Transitions:
  - IDLE→READ on START, latching INSTR.
  - IDLE→IDLE with an ERR pulse on START with an unsupported instruction.
  - READ→EXEC.
  - EXEC→WB.
  - WB→IDLE with a DONE pulse.
- Field decode: op=INSTR[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- R-type (op 0x00), funct→ALU_OPRN:
  - add 0x20→0x01, sub 0x22→0x02, mul 0x2c→0x03.
  - and 0x24→0x04, or 0x25→0x05, nor 0x27→0x06.
  - slt 0x2a→0x07, sll 0x01→0x08, srl 0x02→0x09.
  - Destination is rd.
- I-type, op→ALU_OPRN:
  - addi 0x08→0x01, muli 0x1d→0x03, andi 0x0c→0x04, ori 0x0d→0x05, slti 0x0a→0x07.
  - Destination is rt.
- Operand 2 selection:
  - R-type non-shift: RF_DATA_R2.
  - sll/srl: zero-extended shamt, with OP1=RF_DATA_R2 (rt is shifted).
  - addi/muli/slti: sign-extended imm.
  - andi/ori: zero-extended imm.
- Operand 1: RF_DATA_R1 (rs) for all instructions except shifts.
- Writes to register 0 are suppressed: RF_WRITE stays 0. DONE still pulses, and RESULT/ZERO_FLAG still update.
- Unsupported instruction: no state change beyond the ERR pulse, no register-file or ALU activity, and RESULT is unchanged.
- START while BUSY is ignored: it is neither queued nor flagged.

## Timing
- Reset (asynchronous) clears every output to 0, sets state to IDLE, and aborts any in-flight operation with no write and no DONE.
- After START is sampled at edge 0:
  - READ (cycle 1): RF_READ=1, RF_ADDR_R1/R2 valid.
  - EXEC (cycle 2): operands registered from RF_DATA at the READ→EXEC edge; ALU_OP1/OP2/OPRN are stable throughout EXEC.
  - The EXEC→WB edge captures ALU_OUT into RESULT and ALU_ZERO into ZERO_FLAG.
  - WB (cycle 3): RF_WRITE=1, RF_ADDR_W, RF_DATA_W=RESULT.
  - DONE is high during WB.
- Latency: START edge to DONE high is 3 cycles. Back-to-back issue is possible with START asserted in the IDLE cycle after WB, giving 4 cycles per instruction.
- RF_READ and RF_WRITE are high only in READ and WB respectively. ALU_OPRN is 0 outside EXEC and WB.
- RF_DATA_R1/R2 must be valid by the end of READ; the register file is read combinationally from the addresses.
- ERR is high in the cycle after the rejected START edge, and BUSY stays 0.

## Structure
- Width macros (`DATA_WIDTH, `ALU_OPRN_WIDTH, register address width) and the opcode/funct/ALU_OPRN encodings go in the shared prj_definition.v include. No literals appear in the RTL.
- One combinational sub-module, alu_instr_decode, maps INSTR to {valid, ALU_OPRN, operand-2 select, shift flag, destination address}. The sequencer holds the FSM, the latched instruction, and the operand/result registers.

## Test plan
- Reset mid-EXEC: assert RST during EXEC. Required: all outputs 0 immediately, no RF_WRITE, no DONE, and the next START is accepted normally.
- add r3,r1,r2 with r1=5, r2=7: ALU_OPRN=0x01, RESULT=12, ZERO_FLAG=0, RF_WRITE to r3 in WB, DONE 3 cycles after START.
- sub r4,r1,r1 with r1=9: RESULT=0, ZERO_FLAG=1, write to r4.
- addi r5,r1,0xFFFF with r1=1: ALU_OP2=0xFFFFFFFF, RESULT=0.
- ori r5,r1,0xFFFF with r1=0: ALU_OP2=0x0000FFFF, RESULT=0x0000FFFF.
- sll r6,r2,4 with r2=3: ALU_OP1=3, ALU_OP2=4, ALU_OPRN=0x08, RESULT=48. The same instruction with rd=0 gives RESULT=48, RF_WRITE=0, and DONE=1.
- Instruction 0xFC000000: ERR pulses once and BUSY stays 0. A START held high through a full add operation issues exactly one operation.
